// File: rtl/multidigit_counter_display.sv
// Multi-digit BCD up/down counter driving a time-multiplexed 7-segment display.
// A prescaler turns en-qualified clk cycles into count ticks. A free-running
// scan divider selects one digit at a time. The display outputs are
// combinational from registered state so that polarity changes appear at once.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - asynchronous active-high reset
//   en        - count enable (gates the prescaler)
//   up        - 1 = count up, 0 = count down, sampled on the tick edge
//   load      - synchronous load strobe, overrides a tick in the same cycle
//   load_val  - BCD load value, nibble k = digit k, nibbles above 9 load as 9
//   cathod    - 1 = common-cathode (active-high seg, active-low an), 0 = common-anode
//   blank_lz  - 1 = blank leading zeros (digit 0 is never blanked)
//   seg       - segment drive {g,f,e,d,c,b,a}
//   an        - digit select, one bit per digit
//   count     - registered BCD count
//   wrap      - one-cycle registered pulse on wrap-around
module multidigit_counter_display #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned SCAN_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  cathod,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap
);

    localparam int unsigned CW = 4 * DIGITS;
    localparam int unsigned PW = (CLK_DIV > 1)  ? $clog2(CLK_DIV)  : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] count_q, count_d;
    logic          wrap_q, wrap_d;
    logic [SW-1:0] scan_div_q, scan_div_d;
    logic [IW-1:0] idx_q, idx_d;

    logic          tick_c;
    logic [CW-1:0] step_val_c;
    logic          step_wrap_c;
    logic [CW-1:0] load_sat_c;

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            count_q    <= '0;
            wrap_q     <= 1'b0;
            scan_div_q <= '0;
            idx_q      <= '0;
        end else begin
            presc_q    <= presc_d;
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            scan_div_q <= scan_div_d;
            idx_q      <= idx_d;
        end
    end

    assign tick_c = en && (presc_q == PW'(CLK_DIV - 1));

    // Ripple BCD +/-1; the carry/borrow out of the top digit is exactly the wrap case
    always_comb begin
        logic       carry;
        logic [3:0] dig;
        step_val_c = count_q;
        carry      = 1'b1;
        dig        = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            dig = count_q[4*k +: 4];
            if (carry) begin
                if (up) begin
                    if (dig == 4'd9) begin
                        step_val_c[4*k +: 4] = 4'd0;
                    end else begin
                        step_val_c[4*k +: 4] = dig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        step_val_c[4*k +: 4] = 4'd9;
                    end else begin
                        step_val_c[4*k +: 4] = dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        step_wrap_c = carry;
    end

    // Saturate non-BCD load nibbles to 9
    always_comb begin
        load_sat_c = '0;
        for (int k = 0; k < DIGITS; k++) begin
            load_sat_c[4*k +: 4] = (load_val[4*k +: 4] > 4'd9) ? 4'd9 : load_val[4*k +: 4];
        end
    end

    // Prescaler, count and wrap next-state
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            presc_d = '0;
            count_d = load_sat_c;
        end else if (en) begin
            if (tick_c) begin
                presc_d = '0;
                count_d = step_val_c;
                wrap_d  = step_wrap_c;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Free-running digit scan
    always_comb begin
        scan_div_d = scan_div_q + SW'(1);
        idx_d      = idx_q;
        if (scan_div_q == SW'(SCAN_DIV - 1)) begin
            scan_div_d = '0;
            idx_d      = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // Display decode from registered state
    always_comb begin
        logic              acc;
        logic [DIGITS-1:0] zero_above;
        logic [DIGITS-1:0] hot;
        logic [3:0]        sel_dig;
        logic              sel_blank;
        logic [6:0]        pat;

        // zero_above[k]: digits k..DIGITS-1 are all zero
        acc        = 1'b1;
        zero_above = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            acc           = acc && (count_q[4*k +: 4] == 4'd0);
            zero_above[k] = acc;
        end

        hot       = '0;
        sel_dig   = 4'd0;
        sel_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                hot[k]    = 1'b1;
                sel_dig   = count_q[4*k +: 4];
                sel_blank = blank_lz && (k != 0) && zero_above[k];
            end
        end

        case (sel_dig)
            4'd0:    pat = 7'b0111111;
            4'd1:    pat = 7'b0000110;
            4'd2:    pat = 7'b1011011;
            4'd3:    pat = 7'b1001111;
            4'd4:    pat = 7'b1100110;
            4'd5:    pat = 7'b1101101;
            4'd6:    pat = 7'b1111101;
            4'd7:    pat = 7'b0000111;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1101111;
            default: pat = 7'b0000000;
        endcase
        if (sel_blank) begin
            pat = 7'b0000000;
        end

        seg = cathod ? pat : ~pat;
        an  = cathod ? ~hot : hot;
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_multidigit_counter_display.sv
// Directed self-checking bench for multidigit_counter_display at default
// parameters (DIGITS=4, CLK_DIV=4, SCAN_DIV=2). Inputs change and outputs are
// sampled on the falling edge.
module tb_multidigit_counter_display;

    logic        clk;
    logic        rst;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;
    logic        cathod;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] count;
    logic        wrap;

    int n_vec = 0;
    int n_err = 0;

    multidigit_counter_display dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .cathod   (cathod),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .count    (count),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0000;
        cathod = 1'b1; blank_lz = 1'b0;
        cyc(2);
        #1;
        // Reset state: "0" on digit 0, common-cathode
        chk("rst_count", 32'(count), 32'h0000);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_an", 32'(an), 32'b1110);
        chk("rst_seg", 32'(seg), 32'b0111111);

        // Basic up count: tick every 4 edges
        @(negedge clk);
        rst = 1'b0; en = 1'b1; up = 1'b1;
        cyc(3);
        chk("up_3edges", 32'(count), 32'h0000);
        cyc(1);
        chk("up_4edges", 32'(count), 32'h0001);
        cyc(4);
        chk("up_8edges", 32'(count), 32'h0002);
        // Pause with prescaler at 2; it must resume from there
        cyc(2);
        en = 1'b0;
        cyc(10);
        chk("hold_count", 32'(count), 32'h0002);
        en = 1'b1;
        cyc(1);
        chk("hold_presc3", 32'(count), 32'h0002);
        cyc(1);
        chk("hold_resume", 32'(count), 32'h0003);

        // Up wrap 9999 -> 0000
        load = 1'b1; load_val = 16'h9999; en = 1'b0;
        cyc(1);
        load = 1'b0;
        chk("ld_9999", 32'(count), 32'h9999);
        chk("ld_wrap0", 32'(wrap), 32'd0);
        en = 1'b1; up = 1'b1;
        cyc(3);
        chk("upw_pre", 32'(count), 32'h9999);
        cyc(1);
        chk("upw_count", 32'(count), 32'h0000);
        chk("upw_wrap", 32'(wrap), 32'd1);
        cyc(1);
        chk("upw_wrap_clr", 32'(wrap), 32'd0);
        // Down wrap 0000 -> 9999; up changed mid-period
        up = 1'b0;
        cyc(2);
        chk("dnw_pre", 32'(count), 32'h0000);
        chk("dnw_pre_wrap", 32'(wrap), 32'd0);
        cyc(1);
        chk("dnw_count", 32'(count), 32'h9999);
        chk("dnw_wrap", 32'(wrap), 32'd1);
        cyc(1);
        chk("dnw_wrap_clr", 32'(wrap), 32'd0);

        // Borrow ripple 1000 -> 0999, carry ripple 0199 -> 0200
        load = 1'b1; load_val = 16'h1000;
        cyc(1);
        load = 1'b0; up = 1'b0;
        cyc(4);
        chk("borrow", 32'(count), 32'h0999);
        chk("borrow_wrap", 32'(wrap), 32'd0);
        load = 1'b1; load_val = 16'h0199;
        cyc(1);
        load = 1'b0; up = 1'b1;
        cyc(4);
        chk("carry", 32'(count), 32'h0200);

        // Load on a tick edge wins; prescaler restarts
        load = 1'b1; load_val = 16'h0000; en = 1'b0;
        cyc(1);
        load = 1'b0; en = 1'b1;
        cyc(3);
        load = 1'b1; load_val = 16'h1234;
        cyc(1);
        load = 1'b0;
        chk("ldtick_count", 32'(count), 32'h1234);
        chk("ldtick_wrap", 32'(wrap), 32'd0);
        cyc(3);
        chk("ldtick_hold", 32'(count), 32'h1234);
        cyc(1);
        chk("ldtick_next", 32'(count), 32'h1235);

        // Non-BCD nibbles saturate to 9
        en = 1'b0; load = 1'b1; load_val = 16'h00A5;
        cyc(1);
        chk("sat_a5", 32'(count), 32'h0095);
        load_val = 16'hFFFF;
        cyc(1);
        chk("sat_ffff", 32'(count), 32'h9999);
        load = 1'b0;

        // Scan sequence right after reset release
        rst = 1'b1;
        cyc(1);
        rst = 1'b0; en = 1'b0; cathod = 1'b1; blank_lz = 1'b0;
        #1;
        begin
            logic [3:0] exp_an [8];
            exp_an = '{4'b1110, 4'b1110, 4'b1101, 4'b1101,
                       4'b1011, 4'b1011, 4'b0111, 4'b0111};
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("scan_%0d", i), 32'(an), 32'(exp_an[i]));
                @(negedge clk);
                #1;
            end
        end

        // Leading-zero blanking on 0007, scan resynchronised by reset
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0; load = 1'b1; load_val = 16'h0007; blank_lz = 1'b1; cathod = 1'b1;
        cyc(1);
        load = 1'b0;
        #1;
        chk("blk_an0", 32'(an), 32'b1110);
        chk("blk_seg0", 32'(seg), 32'b0000111);
        cyc(1); #1;
        chk("blk_an1", 32'(an), 32'b1101);
        chk("blk_seg1", 32'(seg), 32'b0000000);
        cyc(2); #1;
        chk("blk_seg2", 32'(seg), 32'b0000000);
        cyc(2); #1;
        chk("blk_an3", 32'(an), 32'b0111);
        chk("blk_seg3", 32'(seg), 32'b0000000);
        cyc(2);
        cathod = 1'b0;
        #1;
        chk("ca_an0", 32'(an), 32'b0001);
        chk("ca_seg0", 32'(seg), 32'b1111000);
        cyc(2); #1;
        chk("ca_an1", 32'(an), 32'b0010);
        chk("ca_seg1", 32'(seg), 32'b1111111);
        blank_lz = 1'b0;
        #1;
        chk("ca_noblank1", 32'(seg), 32'b1000000);

        // Asynchronous reset mid-cycle, while loading
        cathod = 1'b1;
        load = 1'b1; load_val = 16'h4321;
        cyc(1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'h0000);
        chk("arst_an", 32'(an), 32'b1110);
        chk("arst_seg", 32'(seg), 32'b0111111);
        chk("arst_wrap", 32'(wrap), 32'd0);
        cyc(2);
        chk("arst_hold", 32'(count), 32'h0000);
        // Full CLK_DIV wait after release
        rst = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
        cyc(3);
        chk("rel_3edges", 32'(count), 32'h0000);
        cyc(1);
        chk("rel_4edges", 32'(count), 32'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multidigit_counter_display.md
MULTIDIGIT_COUNTER_DISPLAY -- requirements
Module: multidigit_counter_display

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, number of BCD digits, legal range 1..8.
REQ-002 The block SHALL have parameter CLK_DIV, default 4, clk cycles per count tick, legal range >=1.
REQ-003 The block SHALL have parameter SCAN_DIV, default 2, clk cycles per display digit slot, legal range >=1.
REQ-004 The block SHALL have the following ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable.
- up  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  BCD load value; nibble k = digit k.
- cathod  in  1  display polarity: 1 = common-cathode, 0 = common-anode.
- blank_lz  in  1  1 = leading-zero blanking on.
- seg  out  7  segment drive, bit order {g,f,e,d,c,b,a}.
- an  out  DIGITS  digit select, one per digit.
- count  out  4*DIGITS  current BCD count.
- wrap  out  1  one-cycle pulse on count wrap-around.

Function
REQ-005 The prescaler SHALL count 0..CLK_DIV-1 on each clk edge with en=1, hold while en=0, and assert an internal tick on the edge where it equals CLK_DIV-1, then return to 0.
REQ-006 On a tick, count SHALL update by +1 (up=1) or -1 (up=0) as a DIGITS-digit decimal number, with BCD carry/borrow rippling through all digits in the same cycle.
REQ-007 Up-count wrap: all digits 9 -> all digits 0, wrap=1 for exactly that cycle.
REQ-008 Down-count wrap: all digits 0 -> all digits 9, wrap=1 for exactly that cycle.
REQ-009 wrap SHALL be registered, coincident with the count update, and 0 at all other times.
REQ-010 load=1 SHALL load load_val into count on that edge, clear the prescaler to 0, and take priority over any tick in the same cycle; wrap=0 on a load cycle.
REQ-011 Any load_val nibble greater than 9 SHALL be loaded as 9.
REQ-012 up SHALL be sampled on the tick edge only; changing up between ticks SHALL NOT disturb the prescaler.
REQ-013 The scan divider SHALL run continuously, independent of en and load, advancing the digit index 0,1,...,DIGITS-1,0,... every SCAN_DIV cycles.
REQ-014 an SHALL be one-hot on the current digit index: with cathod=1 the selected bit is 0 and the rest 1; with cathod=0 the selected bit is 1 and the rest 0.
REQ-015 seg SHALL decode the selected digit to standard 7-segment patterns, for example 0=0111111, 1=0000110, 8=1111111 in {g..a} active-high form; cathod=1 drives them active-high, cathod=0 inverted.
REQ-016 With blank_lz=1, a digit k>0 SHALL be blanked (all segments off for the current polarity) when digit k and all higher digits are 0; digit 0 is never blanked.
REQ-017 seg and an SHALL be combinational from registered state plus cathod and blank_lz, so a polarity change appears in the same cycle.
REQ-018 count SHALL be the registered BCD value, valid every cycle.

Reset
REQ-019 rst=1 SHALL immediately, without waiting for clk, force count=0, prescaler=0, scan index=0, scan divider=0, wrap=0.
REQ-020 During and after reset, seg SHALL show "0" on digit 0 and an SHALL select digit 0, according to cathod.
REQ-021 Reset asserted mid-count or mid-load SHALL override all activity; counting SHALL resume from 0 with a full CLK_DIV wait after release.

Verification
REQ-022 Defaults, release reset, en=1, up=1 -> count=0001 after 4 edges, 0002 after 8 edges; en=0 for 10 cycles -> count and prescaler hold.
REQ-023 load_val=9999 loaded, up=1, en=1 -> after next tick count=0000 and wrap=1 for one cycle; then up=0 -> after next tick count=9999 and wrap=1.
REQ-024 load=1 on a tick edge with load_val=1234 -> count=1234 with no increment, wrap=0, next change 4 cycles later; load_val=0xA5 in the low byte -> low digits load as 95.
REQ-025 count=0007, blank_lz=1, cathod=1 -> digits 3..1 show seg=0000000 and digit 0 shows 0000111; cathod=0 -> seg=1111111 and 1111000, an inverted.
REQ-026 Scan check: over 8 cycles an steps through digits 0,0,1,1,2,2,3,3 with en=0; assert rst asynchronously mid-cycle -> count=0 and an on digit 0 before the next clk edge.
